dpll_loop_ctrl: RTL and testbench

//  Loop-filter controller for the DPLL: K-counter random-walk filter plus acquisition/lock sequencer.

---
 rtl/dpll_loop_ctrl_pkg.sv | 35 +++
 rtl/dpll_loop_ctrl_ffd.sv | 18 +
 rtl/dpll_loop_ctrl_sync.sv | 38 +++
 rtl/dpll_loop_ctrl.sv | 150 +++++++++++++++
 tb/tb_dpll_loop_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpll_loop_ctrl_pkg.sv
// Shared types and sizing helpers for the DPLL loop-filter controller.
//  dpllState_t : sequencer state encoding (IDLE=0, ACQ=1, TRK=2, LOCKED=3)
//  pdSample_t  : one phase-detector sample (error present, lag direction)
//  pulseDir_t  : direction of the last DCO pulse seen while LOCKED
package dpll_loop_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRK    = 2'd2,
    ST_LOCKED = 2'd3
  } dpllState_t;

  typedef struct packed {
    logic err;
    logic lag;
  } pdSample_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } pulseDir_t;

  // Signed K-counter width: holds -(K_TRK)..K_TRK-1 without overflow.
  function automatic int cntWidth(input int kTrk);
    return $clog2(kTrk) + 1;
  endfunction

  // Width of an up-counter that must reach n-1 (at least 1 bit).
  function automatic int timerWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpll_loop_ctrl_ffd.sv
// Single D flip-flop with asynchronous active-low clear; the building block
// of the phase-detector input synchroniser.
//  clk   : clock
//  reset : async active-low clear
//  d / q : data in / registered data out
module dpll_loop_ctrl_ffd (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/dpll_loop_ctrl_sync.sv
// Phase-detector input synchroniser: two flip-flops per sample bit when
// SYNC_EN=1, straight wires when the detector already lives in this domain.
//  clk    : clock
//  reset  : async active-low clear
//  raw    : pdSample_t straight from the phase detector
//  synced : pdSample_t safe to use in the clk domain
module dpll_loop_ctrl_sync
  import dpll_loop_ctrl_pkg::*;
#(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  pdSample_t raw,
  output pdSample_t synced
);

  localparam int NB = $bits(pdSample_t);

  logic [NB-1:0] rawBits;
  logic [NB-1:0] syncBits;

  assign rawBits = raw;
  assign synced  = syncBits;

  generate
    if (SYNC_EN) begin : g_sync
      for (genvar i = 0; i < NB; i++) begin : g_bit
        logic meta;
        dpll_loop_ctrl_ffd u_ff1 (.clk(clk), .reset(reset), .d(rawBits[i]), .q(meta));
        dpll_loop_ctrl_ffd u_ff2 (.clk(clk), .reset(reset), .d(meta),       .q(syncBits[i]));
      end
    end else begin : g_bypass
      assign syncBits = rawBits;
    end
  endgenerate

endmodule

// File: rtl/dpll_loop_ctrl.sv
// DPLL loop-filter controller: K-counter random-walk filter plus an
// acquisition / tracking / lock sequencer. Turns phase-detector samples into
// single-cycle advance/retard requests for the DCO.
//  clk       : clock, all logic on posedge
//  reset     : async active-low reset
//  en        : loop enable; low forces IDLE on the next edge
//  pd_err    : phase error present this sample
//  pd_lag    : 1 = output lags reference (count up), 0 = leads (count down)
//  inc_pulse : 1-cycle advance request
//  dec_pulse : 1-cycle retard request
//  locked    : level, high while LOCKED
//  lost_lock : 1-cycle pulse on LOCKED->ACQ
//  state     : current sequencer state
module dpll_loop_ctrl
  import dpll_loop_ctrl_pkg::*;
#(
  parameter int K_ACQ    = 8,
  parameter int K_TRK    = 64,
  parameter int ACQ_CYC  = 1024,
  parameter int LOCK_CYC = 256,
  parameter bit SYNC_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       pd_err,
  input  logic       pd_lag,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       locked,
  output logic       lost_lock,
  output logic [1:0] state
);

  localparam int CW = cntWidth(K_TRK);
  localparam int SW = CW + 1;          // one bit of headroom to see +K
  localparam int AW = timerWidth(ACQ_CYC);
  localparam int QW = timerWidth(LOCK_CYC);

  pdSample_t pdRaw, pdSync;
  assign pdRaw = '{err: pd_err, lag: pd_lag};

  dpll_loop_ctrl_sync #(.SYNC_EN(SYNC_EN)) u_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (pdRaw),
    .synced(pdSync)
  );

  dpllState_t           curState;
  logic signed [CW-1:0] kCnt;
  logic [AW-1:0]        acqTimer;
  logic [QW-1:0]        quietCnt;
  pulseDir_t            lastDir;

  assign state = curState;

  // Next K-counter value and overflow detection against the active modulus.
  logic signed [SW-1:0] kMod, cntExt, cntNext;
  logic                 hitUp, hitDn;
  pulseDir_t            pulseDir;

  always_comb begin
    kMod    = (curState == ST_ACQ) ? SW'(K_ACQ) : SW'(K_TRK);
    cntExt  = {kCnt[CW-1], kCnt};
    cntNext = cntExt;
    if (pdSync.err) cntNext = pdSync.lag ? cntExt + SW'(1) : cntExt - SW'(1);
    hitUp    = (curState != ST_IDLE) && (cntNext == kMod);
    hitDn    = (curState != ST_IDLE) && (cntNext == -kMod);
    pulseDir = hitUp ? DIR_UP : (hitDn ? DIR_DN : DIR_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState  <= ST_IDLE;
      kCnt      <= '0;
      acqTimer  <= '0;
      quietCnt  <= '0;
      lastDir   <= DIR_NONE;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      locked    <= 1'b0;
      lost_lock <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      lost_lock <= 1'b0;
      if (!en) begin
        // Disable wins over everything, including a pulse about to fire.
        curState <= ST_IDLE;
        kCnt     <= '0;
        acqTimer <= '0;
        quietCnt <= '0;
        lastDir  <= DIR_NONE;
        locked   <= 1'b0;
      end else if (curState == ST_IDLE) begin
        curState <= ST_ACQ;
        kCnt     <= '0;
        acqTimer <= '0;
        quietCnt <= '0;
      end else begin
        inc_pulse <= hitUp;
        dec_pulse <= hitDn;
        kCnt      <= (hitUp || hitDn) ? '0 : cntNext[CW-1:0];
        case (curState)
          ST_ACQ: begin
            if (acqTimer == AW'(ACQ_CYC - 1)) begin
              // Modulus widens: any residual count is dropped.
              curState <= ST_TRK;
              kCnt     <= '0;
              acqTimer <= '0;
              quietCnt <= '0;
            end else begin
              acqTimer <= acqTimer + AW'(1);
            end
          end
          ST_TRK: begin
            if (pdSync.err) begin
              quietCnt <= '0;
            end else if (quietCnt == QW'(LOCK_CYC - 1)) begin
              curState <= ST_LOCKED;
              locked   <= 1'b1;
            end else begin
              quietCnt <= quietCnt + QW'(1);
            end
          end
          default: begin
            // Two pulses in the same direction with nothing opposite in
            // between means the loop is walking away: re-acquire. The second
            // pulse itself still goes out to the DCO.
            if (pulseDir != DIR_NONE) begin
              if (pulseDir == lastDir) begin
                curState  <= ST_ACQ;
                lost_lock <= 1'b1;
                locked    <= 1'b0;
                kCnt      <= '0;
                acqTimer  <= '0;
                quietCnt  <= '0;
                lastDir   <= DIR_NONE;
              end else begin
                lastDir <= pulseDir;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
module tb_dpll_loop_ctrl;

  localparam int K_ACQ    = 8;
  localparam int K_TRK    = 64;
  localparam int ACQ_CYC  = 1024;
  localparam int LOCK_CYC = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       pd_err = 1'b0;
  logic       pd_lag = 1'b0;
  logic       inc_pulse, dec_pulse, locked, lost_lock;
  logic [1:0] state;

  dpll_loop_ctrl #(
    .K_ACQ(K_ACQ), .K_TRK(K_TRK), .ACQ_CYC(ACQ_CYC), .LOCK_CYC(LOCK_CYC), .SYNC_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pd_err(pd_err), .pd_lag(pd_lag),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .locked(locked),
    .lost_lock(lost_lock), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: what the loop should do each clock, in plain ints.
  int mState, mCnt, mTimer, mQuiet, mLastDir;
  bit mInc, mDec, mLost;
  bit dErr[2], dLag[2];  // phase-detector samples still in transit, [1] oldest

  task automatic mdlReset();
    mState = 0; mCnt = 0; mTimer = 0; mQuiet = 0; mLastDir = 0;
    mInc = 0; mDec = 0; mLost = 0;
    dErr[0] = 0; dErr[1] = 0; dLag[0] = 0; dLag[1] = 0;
  endtask

  task automatic mdlStep();
    bit eS, lS;
    int k, dir;
    eS = dErr[1]; lS = dLag[1];
    dErr[1] = dErr[0]; dLag[1] = dLag[0];
    dErr[0] = pd_err;  dLag[0] = pd_lag;
    mInc = 0; mDec = 0; mLost = 0;
    if (!en) begin
      mState = 0; mCnt = 0; mTimer = 0; mQuiet = 0; mLastDir = 0;
    end else if (mState == 0) begin
      mState = 1; mCnt = 0; mTimer = 0; mQuiet = 0;
    end else begin
      k = (mState == 1) ? K_ACQ : K_TRK;
      if (eS) mCnt += lS ? 1 : -1;
      dir = (mCnt == k) ? 1 : ((mCnt == -k) ? -1 : 0);
      if (dir != 0) mCnt = 0;
      mInc = (dir > 0);
      mDec = (dir < 0);
      case (mState)
        1: begin
          mTimer++;
          if (mTimer == ACQ_CYC) begin mState = 2; mCnt = 0; mTimer = 0; mQuiet = 0; end
        end
        2: begin
          if (eS) mQuiet = 0;
          else begin
            mQuiet++;
            if (mQuiet == LOCK_CYC) mState = 3;
          end
        end
        default: begin
          if (dir != 0) begin
            if (dir == mLastDir) begin mState = 1; mLost = 1; mCnt = 0; mLastDir = 0; end
            else mLastDir = dir;
          end
        end
      endcase
    end
  endtask

  function automatic logic [5:0] outs();
    return {inc_pulse, dec_pulse, locked, lost_lock, state};
  endfunction

  function automatic logic [5:0] mdlOuts();
    return {mInc, mDec, (mState == 3), mLost, 2'(mState)};
  endfunction

  // Advance one clock: model follows the edge, outputs settle by the negedge.
  task automatic step();
    @(posedge clk);
    if (!reset) mdlReset(); else mdlStep();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    mdlReset();
    step(); step();
    if (inc_pulse !== 1'b0) begin errors++; $display("FAIL reset_inc: got %b want 0", inc_pulse); end
    checks++;
    if (dec_pulse !== 1'b0) begin errors++; $display("FAIL reset_dec: got %b want 0", dec_pulse); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++;
    if (lost_lock !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b want 0", lost_lock); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    reset = 1'b1;
    step();
  endtask

  // ACQ with constant lag: first advance 11 cycles after en, then every 8;
  // async reset mid-count clears everything and ACQ restarts from zero.
  task automatic test_acq_inc_and_midreset();
    int firstInc, secondInc;
    firstInc = -1; secondInc = -1;
    en = 1'b1;
    step();
    pd_err = 1'b1; pd_lag = 1'b1;
    for (int c = 2; c <= 24; c++) begin
      step();
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL acq_inc_c%0d: got %b want %b", c, outs(), mdlOuts()); end
      checks++;
      if (inc_pulse) begin
        if (firstInc < 0) firstInc = c;
        else if (secondInc < 0) secondInc = c;
      end
    end
    if (firstInc !== 11) begin errors++; $display("FAIL acq_first_inc: got %0d want 11", firstInc); end
    checks++;
    if (secondInc !== 19) begin errors++; $display("FAIL acq_second_inc: got %0d want 19", secondInc); end
    checks++;
    // counter now at 5 in ACQ
    #2 reset = 1'b0;
    mdlReset();
    #1;
    if (outs() !== 6'd0) begin errors++; $display("FAIL midreset_outs: got %b want 000000", outs()); end
    checks++;
    step();
    if (state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", state); end
    checks++;
    pd_err = 1'b0; pd_lag = 1'b0; en = 1'b0;
    reset = 1'b1;
    step();
    en = 1'b1;
    step();
    pd_err = 1'b1; pd_lag = 1'b1;
    firstInc = -1;
    for (int c = 2; c <= 14; c++) begin
      step();
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL restart_c%0d: got %b want %b", c, outs(), mdlOuts()); end
      checks++;
      if (inc_pulse && firstInc < 0) firstInc = c;
    end
    if (firstInc !== 11) begin errors++; $display("FAIL restart_first_inc: got %0d want 11", firstInc); end
    checks++;
  endtask

  // ACQ with lead: retard every 8; after 1024 ACQ cycles TRK with spacing 64.
  task automatic test_acq_to_trk();
    int lastDec, firstGap, lastGap, trkAt;
    lastDec = -1; firstGap = -1; lastGap = -1; trkAt = -1;
    en = 1'b0; pd_err = 1'b0; pd_lag = 1'b0;
    step(); step(); step();
    en = 1'b1;
    step();
    pd_err = 1'b1; pd_lag = 1'b0;
    for (int c = 2; c <= 1300; c++) begin
      step();
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL acq_trk_c%0d: got %b want %b", c, outs(), mdlOuts()); end
      checks++;
      if (state == 2'd2 && trkAt < 0) trkAt = c;
      if (dec_pulse) begin
        if (lastDec > 0) begin
          if (firstGap < 0) firstGap = c - lastDec;
          lastGap = c - lastDec;
        end
        lastDec = c;
      end
    end
    if (trkAt !== 1025) begin errors++; $display("FAIL trk_entry: got %0d want 1025", trkAt); end
    checks++;
    if (firstGap !== K_ACQ) begin errors++; $display("FAIL acq_dec_gap: got %0d want %0d", firstGap, K_ACQ); end
    checks++;
    if (lastGap !== K_TRK) begin errors++; $display("FAIL trk_dec_gap: got %0d want %0d", lastGap, K_TRK); end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL trk_state: got %0d want 2", state); end
    checks++;
  endtask

  // TRK quiet period; one error on the 256th sample restarts the 256 count.
  task automatic test_lock();
    int lockAt;
    lockAt = -1;
    for (int j = 1; j <= 600; j++) begin
      pd_err = (j == 256);
      step();
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL lock_c%0d: got %b want %b", j, outs(), mdlOuts()); end
      checks++;
      if (j == 258 && locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
      if (j == 258) checks++;
      if (locked && lockAt < 0) lockAt = j;
    end
    if (lockAt !== 514) begin errors++; $display("FAIL lock_edge: got %0d want 514", lockAt); end
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL lock_state: got %0d want 3", state); end
    checks++;
  endtask

  // LOCKED, persistent lag: second advance drops lock and is still issued.
  task automatic test_lost_lock();
    int nInc, lostAt, incAtLost;
    bit lostWithInc;
    nInc = 0; lostAt = -1; incAtLost = -1; lostWithInc = 0;
    pd_err = 1'b1; pd_lag = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL lost_c%0d: got %b want %b", c, outs(), mdlOuts()); end
      checks++;
      if (inc_pulse) nInc++;
      if (lost_lock && lostAt < 0) begin
        lostAt = c; incAtLost = nInc; lostWithInc = inc_pulse;
        if (state !== 2'd1 || locked !== 1'b0) begin
          errors++; $display("FAIL lost_state: got state=%0d locked=%b want 1/0", state, locked);
        end
        checks++;
      end else if (lostAt > 0) begin
        if (lost_lock !== 1'b0) begin errors++; $display("FAIL lost_width: got %b want 0", lost_lock); end
        checks++;
        break;
      end
    end
    if (lostAt < 0) begin errors++; $display("FAIL lost_timeout: got none want lost_lock within 400"); end
    checks++;
    if (incAtLost !== 2) begin errors++; $display("FAIL lost_inc_count: got %0d want 2", incAtLost); end
    checks++;
    if (lostWithInc !== 1'b1) begin errors++; $display("FAIL lost_pulse_out: got %b want 1", lostWithInc); end
    checks++;
  endtask

  // en dropped in LOCKED with counter at 63 and an error arriving: no pulse.
  task automatic test_en_drop();
    int n;
    en = 1'b0; pd_err = 1'b0;
    step();
    if (state !== 2'd0) begin errors++; $display("FAIL endrop_idle: got %0d want 0", state); end
    checks++;
    en = 1'b1;
    n = 0;
    while (mState != 3 && n < 1400) begin
      step(); n++;
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL relock_c%0d: got %b want %b", n, outs(), mdlOuts()); end
      checks++;
    end
    if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked); end
    checks++;
    pd_err = 1'b1; pd_lag = 1'b1;
    n = 0;
    while (!(mState == 3 && mCnt == K_TRK - 1 && dErr[1] && dLag[1]) && n < 300) begin
      step(); n++;
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL fill_c%0d: got %b want %b", n, outs(), mdlOuts()); end
      checks++;
    end
    if (n >= 300) begin errors++; $display("FAIL fill_timeout: got %0d cycles want <300", n); end
    checks++;
    en = 1'b0;
    step();
    if (inc_pulse !== 1'b0) begin errors++; $display("FAIL endrop_inc: got %b want 0", inc_pulse); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL endrop_state: got %0d want 0", state); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL endrop_locked: got %b want 0", locked); end
    checks++;
  endtask

  // Random phase-detector activity in phases of varying error density.
  task automatic test_random();
    int errPct, lagPct;
    errPct = 50; lagPct = 50;
    en = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      if (c % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: errPct = 0;
          1: errPct = 5;
          2: errPct = 60;
          default: errPct = 100;
        endcase
        lagPct = $urandom_range(0, 1) ? 85 : 15;
      end
      en     = ($urandom_range(0, 999) != 0);
      pd_err = ($urandom_range(0, 99) < errPct);
      pd_lag = ($urandom_range(0, 99) < lagPct);
      step();
      if (outs() !== mdlOuts()) begin errors++; $display("FAIL rand_c%0d: got %b want %b", c, outs(), mdlOuts()); end
      checks++;
    end
  endtask

  initial begin
    mdlReset();
    test_reset();
    test_acq_inc_and_midreset();
    test_acq_to_trk();
    test_lock();
    test_lost_lock();
    test_en_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
